// File: rtl/spmv_pkg.sv
// Shared types for the SpMV accumulation controller: FSM state encoding and
// accumulator depth derivation.
package spmv_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int unsigned spmv_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/spmv_acc_ctrl.sv
// Read-modify-write accumulation controller for SpMV partial sums held in an
// external single-clock dual-port RAM with write-to-read bypass.
module spmv_acc_ctrl
    import spmv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  drain_start,
    output logic                  busy,
    output logic                  drain_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned DEPTH = spmv_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_e                  r_state;
    state_e                  w_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_rd_done;
    logic                    r_s1_valid;
    logic                    r_s1_zero;
    logic [ADDR_WIDTH-1:0]   r_s1_addr;
    logic [DATA_WIDTH-1:0]   r_s1_data;
    logic                    r_out_valid;
    logic [ADDR_WIDTH-1:0]   r_out_addr;
    logic                    r_drain_done;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_last_hs;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:  if (r_cnt == LAST_IDX) w_next = ST_ACCUM;
            ST_ACCUM: if (drain_start)       w_next = ST_DRAIN;
            ST_DRAIN: if (w_last_hs)         w_next = ST_ACCUM;
            default:                         w_next = ST_INIT;
        endcase
    end

    // Per-state handshake and read-port control
    always_comb begin
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_issue    = 1'b0;
        w_last_hs  = 1'b0;
        ram_re     = 1'b0;
        ram_raddr  = r_cnt;
        case (r_state)
            ST_ACCUM: begin
                w_in_ready = !drain_start;
                w_accept   = in_valid && !drain_start;
                ram_re     = w_accept;
                ram_raddr  = in_addr;
            end
            ST_DRAIN: begin
                // Read-issue is the only path from out_ready into the RAM port
                w_issue   = !r_rd_done && (!r_out_valid || out_ready);
                w_last_hs = r_out_valid && out_ready && (r_out_addr == LAST_IDX);
                ram_re    = w_issue;
            end
            default: ;
        endcase
    end

    // Write stage, sweep counter and drain output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_rd_done    <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_zero    <= 1'b1;
            r_s1_addr    <= '0;
            r_s1_data    <= '0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_drain_done <= 1'b0;
        end else begin
            r_s1_valid   <= 1'b0;
            r_s1_zero    <= 1'b1;
            r_drain_done <= w_last_hs;
            case (r_state)
                ST_INIT: begin
                    r_s1_valid <= 1'b1;
                    r_s1_addr  <= r_cnt;
                    r_cnt      <= r_cnt + ADDR_WIDTH'(1);
                end
                ST_ACCUM: begin
                    r_rd_done <= 1'b0;
                    if (w_accept) begin
                        r_s1_valid <= 1'b1;
                        r_s1_zero  <= 1'b0;
                        r_s1_addr  <= in_addr;
                        r_s1_data  <= in_data;
                    end
                end
                ST_DRAIN: begin
                    // Each issued read schedules the zero write of the same word one cycle later
                    if (w_issue) begin
                        r_s1_valid  <= 1'b1;
                        r_s1_addr   <= r_cnt;
                        r_cnt       <= r_cnt + ADDR_WIDTH'(1);
                        r_out_addr  <= r_cnt;
                        r_out_valid <= 1'b1;
                        if (r_cnt == LAST_IDX) r_rd_done <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = (r_state != ST_ACCUM);
    assign drain_done = r_drain_done;
    assign out_valid  = r_out_valid;
    assign out_addr   = r_out_addr;
    // RAM holds its output while ram_re is low, so out_data is stable under stall
    assign out_data   = r_out_valid ? ram_dout : '0;
    assign ram_we     = r_s1_valid;
    assign ram_waddr  = r_s1_addr;
    assign ram_din    = r_s1_zero ? '0 : DATA_WIDTH'(ram_dout + r_s1_data);

endmodule

// File: tb/tb_spmv_acc_ctrl.sv
// Directed bench for spmv_acc_ctrl with a bypassing dual-port RAM model and a
// scoreboard of expected drained words.
module tb_spmv_acc_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_start;
    logic          busy;
    logic          drain_done;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic [AW-1:0] ram_raddr;
    logic          ram_re;
    logic [AW-1:0] ram_waddr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] model [DEPTH];
    logic [AW-1:0] sb_addr [$];
    logic [DW-1:0] sb_data [$];
    int            n_checks;
    int            n_errors;
    int            n_hs;

    spmv_acc_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .drain_start(drain_start), .busy(busy), .drain_done(drain_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_waddr(ram_waddr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, same-cycle write bypassed to a read of the same address
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        if (ram_re) ram_dout <= (ram_we && ram_waddr == ram_raddr) ? ram_din : mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every presented drain word is checked against the scoreboard head; popped on handshake
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("sb_nonempty", 64'(sb_addr.size() != 0), 64'd1);
            if (sb_addr.size() != 0) begin
                chk("drain_addr", 64'(out_addr), 64'(sb_addr[0]));
                chk("drain_data", 64'(out_data), 64'(sb_data[0]));
                if (out_ready) begin
                    void'(sb_addr.pop_front());
                    void'(sb_data.pop_front());
                    n_hs++;
                end
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        @(negedge clk);
        chk("accept_ready", 64'(in_ready), 64'd1);
        chk("accept_re", 64'(ram_re), 64'd1);
        chk("accept_raddr", 64'(ram_raddr), 64'(a));
        model[a] = model[a] + d;
        @(posedge clk); #1;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        chk("init_busy_cycles", 64'(n), 64'(DEPTH));
        chk("ready_after_init", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic push_expected();
        for (int a = 0; a < int'(DEPTH); a++) begin
            sb_addr.push_back(AW'(a));
            sb_data.push_back(model[a]);
            model[a] = '0;
        end
    endtask

    task automatic do_drain(input bit rand_ready, input bit junk_in);
        int pulses;
        int after;
        int hs0;
        push_expected();
        hs0         = n_hs;
        drain_start = 1'b1;
        out_ready   = 1'b1;
        in_valid    = junk_in;
        in_addr     = AW'(2);
        in_data     = 32'hDEAD_0001;
        @(negedge clk);
        chk("ready_low_on_drain_start", 64'(in_ready), 64'd0);
        chk("no_read_on_drain_start", 64'(ram_re), 64'd0);
        @(posedge clk); #1;
        drain_start = 1'b0;
        in_valid    = 1'b0;
        if (!rand_ready) begin
            @(negedge clk);
            chk("first_valid_not_early", 64'(out_valid), 64'd0);
            chk("busy_in_drain", 64'(busy), 64'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("first_valid_latency", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        pulses = 0;
        after  = -1;
        for (int c = 0; c < 150; c++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (drain_done) begin
                pulses++;
                if (after < 0) after = 0;
            end else if (after >= 0) begin
                after++;
            end
            @(posedge clk); #1;
            if (after >= 3) break;
        end
        out_ready = 1'b1;
        chk("drain_done_pulses", 64'(pulses), 64'd1);
        chk("drain_word_count", 64'(n_hs - hs0), 64'(DEPTH));
        chk("sb_drained", 64'(sb_addr.size()), 64'd0);
        @(negedge clk);
        chk("ready_after_drain", 64'(in_ready), 64'd1);
        chk("idle_after_drain", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit found;
        n_checks    = 0;
        n_errors    = 0;
        n_hs        = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_addr     = '0;
        in_data     = '0;
        drain_start = 1'b0;
        out_ready   = 1'b1;
        for (int a = 0; a < int'(DEPTH); a++) model[a] = '0;

        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_drain_done", 64'(drain_done), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ram_re", 64'(ram_re), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_waddr", 64'(ram_waddr), 64'd0);
        chk("rst_ram_raddr", 64'(ram_raddr), 64'd0);
        chk("rst_ram_din", 64'(ram_din), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init();

        // Fresh accumulators drain as zeros
        do_drain(1'b0, 1'b0);

        // Same-address streaming; a product offered with drain_start must be dropped
        send(AW'(5), 32'd1);
        send(AW'(5), 32'd2);
        send(AW'(5), 32'd3);
        send(AW'(5), 32'd4);
        in_valid = 1'b0;
        do_drain(1'b0, 1'b1);

        // Wrap-around sum with an explicit write-back check
        send(AW'(0), 32'hFFFF_FFFF);
        send(AW'(0), 32'h0000_0002);
        in_valid = 1'b0;
        @(negedge clk);
        chk("wb_we", 64'(ram_we), 64'd1);
        chk("wb_waddr", 64'(ram_waddr), 64'd0);
        chk("wb_din", 64'(ram_din), 64'(model[0]));
        @(posedge clk); #1;
        do_drain(1'b0, 1'b0);

        // Mixed traffic, then drain under random backpressure
        for (int i = 0; i < 12; i++)
            send(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        send(AW'(15), 32'h1234_5678);
        in_valid = 1'b0;
        do_drain(1'b1, 1'b0);

        // Drain immediately after the last accept, then again back-to-back
        send(AW'(0), 32'd7);
        do_drain(1'b0, 1'b0);
        do_drain(1'b0, 1'b0);

        // Reset in the middle of a drain
        send(AW'(3), 32'h55);
        send(AW'(9), 32'h66);
        in_valid = 1'b0;
        push_expected();
        drain_start = 1'b1;
        @(posedge clk); #1;
        drain_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid && out_addr == AW'(8)) begin
                found = 1'b1;
                break;
            end
        end
        chk("reset_word8_seen", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd1);
        chk("midrst_ram_we", 64'(ram_we), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        sb_addr.delete();
        sb_data.delete();
        for (int a = 0; a < int'(DEPTH); a++) model[a] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init();
        do_drain(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spmv_acc_ctrl.md
# spmv_acc_ctrl

Read-modify-write accumulation controller for SpMV partial sums. It accepts a stream of (row index, product) pairs and adds each product into a `DATA_WIDTH`-bit accumulator word held in an external single-clock dual-port RAM (`simple_dpram_sclk`, `ENABLE_BYPASS=1`). It drives that RAM's ports and consumes its read data. On request it drains every accumulator word to a downstream port, zeroing each word as it goes, so the next vector starts from zero.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, accumulator address width; `DEPTH = 1<<ADDR_WIDTH` words
- `DATA_WIDTH`, 32, accumulator and product width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  product valid
- `in_ready`  out  1  product accepted when `in_valid && in_ready`
- `in_addr`  in  `ADDR_WIDTH`  row index
- `in_data`  in  `DATA_WIDTH`  product value
- `drain_start`  in  1  single-cycle request to dump all accumulators
- `busy`  out  1  high in INIT and DRAIN
- `drain_done`  out  1  one-cycle pulse at the end of a drain
- `out_valid`  out  1  drained word valid
- `out_ready`  in  1  downstream accepts drained word
- `out_addr`  out  `ADDR_WIDTH`  index of drained word
- `out_data`  out  `DATA_WIDTH`  drained accumulator value
- `ram_raddr`  out  `ADDR_WIDTH`  RAM read address
- `ram_re`  out  1  RAM read enable
- `ram_waddr`  out  `ADDR_WIDTH`  RAM write address
- `ram_we`  out  1  RAM write enable
- `ram_din`  out  `DATA_WIDTH`  RAM write data
- `ram_dout`  in  `DATA_WIDTH`  RAM read data; valid the cycle after `ram_re`

## Operation
- The FSM has three states: INIT, ACCUM and DRAIN. Reset enters INIT.
- **INIT**
  - Writes 0 to addresses 0..DEPTH-1, one per cycle, then enters ACCUM.
  - `in_ready=0`; `drain_start` is ignored.
- **ACCUM**
  - `in_ready=1`.
  - On accept at cycle T: `ram_re=1`, `ram_raddr=in_addr`; the address and data are registered as stage-1.
  - At T+1: `ram_we=1`, `ram_waddr` = stage-1 address, `ram_din = ram_dout + stage-1 data`, modulo 2^`DATA_WIDTH` (carry dropped).
  - Back-to-back hits to the same address are resolved by the RAM bypass, which returns `ram_din` written at T+1 for a read issued at T+1. No stall is ever inserted.
  - `drain_start` while in ACCUM: `in_ready` goes 0 the same cycle and no accept happens that cycle. Next cycle the FSM enters DRAIN, and any pending stage-1 write still completes.
- **DRAIN**
  - A sweep counter k runs 0..DEPTH-1.
  - A read of k is issued when `!out_valid || out_ready`.
  - The cycle after the read: `out_valid=1`, `out_addr=k`, `out_data=ram_dout`, plus a zero write with `ram_we=1`, `ram_waddr=k`, `ram_din=0`.
  - The zero write is never issued in the same cycle as the read of the same address.
  - `out_data` stays stable while stalled because `ram_re=0`.
  - After word DEPTH-1 is accepted: `drain_done` pulses, then the FSM returns to ACCUM.
  - `drain_start` is ignored in DRAIN.
- **Reset** mid-operation at any point aborts everything and re-enters INIT. RAM contents are rewritten by INIT.

## Timing
- Reset values: `in_ready=0`, `busy=1`, `drain_done=0`, `out_valid=0`, `ram_re=0`, `ram_we=0`; all addresses and data are 0.
- Accumulate throughput is 1 per cycle. Write-back latency is 1 cycle after accept.
- INIT lasts DEPTH cycles. `in_ready` rises on the cycle after the last zero write.
- Drain with `out_ready` held high: first `out_valid` appears 2 cycles after `drain_start`, followed by DEPTH consecutive words.
- `drain_done` is asserted in the cycle after the final output handshake.
- `ram_re` and `ram_we` are driven from registers or the FSM only; they have no combinational path from `out_ready`, except the read-issue enable in DRAIN.

## Structure
- Shared package `spmv_pkg`: the state enum (INIT, ACCUM, DRAIN) and the DEPTH derivation function.
- No sub-module. The RAM is instantiated by the parent alongside this block with `ENABLE_BYPASS=1` and matching widths.
- A counter of `ADDR_WIDTH` bits is shared between INIT and DRAIN. The terminal condition is counter == DEPTH-1.

## Test plan
- **Reset/INIT:** deassert `rst_n` -> `busy=1` for DEPTH cycles, then `in_ready=1`; a drain returns DEPTH zeros.
- **Same-address streaming:** with `ADDR_WIDTH=4`, products 1,2,3,4 to address 5 on consecutive cycles, then drain -> address 5 yields 10, all others 0.
- **Wrap arithmetic:** 0xFFFFFFFF then 0x2 to address 0 -> drained value 0x1.
- **Drain backpressure:** toggle `out_ready` pseudo-randomly -> 16 words in address order 0..15, no loss or duplication, `out_data` stable during stalls, one `drain_done` pulse.
- **Last write vs. first read:** `drain_start` asserted the cycle after accepting (addr 0, 7) -> address 0 drains as 7. A second drain immediately after returns all zeros.
- **Mid-drain reset:** assert `rst_n=0` at word 8 -> `out_valid=0` immediately; INIT re-runs and a subsequent drain returns all zeros.
